actuator_guard: RTL
===================

Name: actuator_guard

Overview:
- Downstream stage of the farming decision logic.
- Takes raw per-actuator on-requests (pump, heater, fan, grow-light) and converts them into protected drive signals for the relay pins.
- Enforces minimum on-time, minimum off-time (cooldown), maximum continuous on-time with a sticky timeout fault, a global simultaneous-load budget and single-start-per-cycle inrush staggering.
- The override input forces all loads off.

Parameters:
- TICK_DIV, 25000: clk cycles per timer tick (1 ms at 25 MHz).
- CNT_W, 8: width of all tick counters.
- MIN_ON, 3: minimum ticks a channel stays on once started.
- MIN_OFF, 2: cooldown ticks after a channel turns off.
- MAX_ON, 200: maximum consecutive ON ticks before forced off with fault.
- MAX_ACTIVE, 2: maximum channels driven simultaneously.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; low freezes prescaler, timers and FSMs, and holds outputs.
- req  input  4  on-requests; [0] pump, [1] heater, [2] fan, [3] light.
- override  input  1  manual override; high forces all drives off.
- clr_timeout  input  1  single-cycle pulse; clears all timeout flags.
- drive  output  4  registered actuator drives, same bit order as req.
- timeout  output  4  sticky per-channel MAX_ON fault flags.
- active_cnt  output  3  number of channels currently in ON.

Behaviour:
Reset:
- Asynchronous, active-low: all channels go to IDLE.
- drive=0, timeout=0, active_cnt=0; prescaler and all counters cleared.
- Reset asserted mid-operation drops drive immediately; no cooldown is applied after reset release.

Prescaler:
- Free-running while ena=1.
- tick is a 1-cycle internal pulse when the count reaches TICK_DIV-1; the count then wraps to 0.
- Timers decrement only on tick, and saturate at 0.

Per-channel FSM (IDLE, ON, COOL):
- IDLE:
  - drive=0.
  - Goes to ON when req[i]=1, timeout[i]=0, override=0, active_cnt<MAX_ACTIVE, and the channel wins the start arbitration.
  - On entering ON: load min_cnt=MIN_ON and on_cnt=0.
- ON:
  - drive=1.
  - On each tick: min_cnt decrements if nonzero; on_cnt increments.
  - When min_cnt=0 and req[i]=0: go to COOL.
  - When on_cnt reaches MAX_ON: go to COOL and set timeout[i]. This takes priority and applies regardless of req.
  - On entering COOL: load off_cnt=MIN_OFF.
- COOL:
  - drive=0.
  - off_cnt decrements on tick.
  - Goes to IDLE on the edge after off_cnt reaches 0.
  - req is ignored while in COOL.

Start arbitration:
- At most one IDLE→ON transition per clk cycle.
- The lowest-index eligible channel wins; losers retry the next cycle.
- A channel leaving ON and another entering ON on the same edge is allowed. The budget check uses the pre-edge active_cnt, so the new start is only admitted if the pre-edge count is below MAX_ACTIVE.

Latency:
- req high sampled at edge n gives drive high after edge n (1 cycle), when the channel is eligible.
- Effective minimum on-duration is between (MIN_ON-1)*TICK_DIV+1 and MIN_ON*TICK_DIV cycles, depending on prescaler phase. The same bound applies to MIN_OFF.

Override:
- Sampled each edge.
- Every channel in ON moves to COOL (off_cnt=MIN_OFF) on the next edge, with drive low and no min-on check.
- No IDLE→ON transitions while override=1.
- on_cnt does not set timeout when the exit is caused by override.

Timeout:
- A set flag blocks its channel in IDLE until clr_timeout.
- clr_timeout and a new timeout on the same edge: set wins.

ena=0:
- All registers hold, including the prescaler.
- override and clr_timeout are still honoured.

active_cnt:
- Registered; equals the popcount of drive.

Test Plan:
Bench parameters: TICK_DIV=4, MIN_ON=3, MIN_OFF=2, MAX_ON=10, MAX_ACTIVE=2.
1. Minimum on-time:
   - Stimulus: 1-cycle pulse on req[0].
   - Required: drive[0] rises 1 cycle later and stays high 9–12 cycles.
   - Required: then low, with req[0]=1 ignored for 5–8 further cycles (COOL), then restarts 1 cycle after IDLE.
2. Budget and arbitration:
   - Stimulus: req=4'b1111 from IDLE.
   - Required: drive goes 0001 → 0011 on consecutive cycles, then stays at 0011; active_cnt=2; channels 2/3 stay off.
   - Required: after req[0] drops and channel 0 is past min-on, channel 2 starts on the following cycle.
3. Max-on timeout:
   - Stimulus: hold req[1]=1.
   - Required: drive[1] forced low after 10 ticks (37–40 cycles); timeout[1]=1; no restart while req[1]=1.
   - Required: after a clr_timeout pulse, drive[1] restarts once COOL has elapsed.
4. Override:
   - Stimulus: with drive=0011, assert override.
   - Required: drive=0000 on the next edge; timeout unchanged; no starts while override=1.
   - Required: after release, channels restart only after MIN_OFF cooldown.
5. Reset mid-ON:
   - Stimulus: drive[0]=1, pull rst_n low asynchronously between edges.
   - Required: drive=0 immediately.
   - Required: after release with req[0]=1, drive[0] rises 1 cycle later (no cooldown).
6. ena freeze:
   - Stimulus: drive[0]=1 mid-min-on, set ena=0 for 20 cycles with req[0]=0.
   - Required: drive[0] stays 1 throughout; after ena=1, the remaining min-on completes, then drive[0] drops.

Source files
------------

// File: rtl/actuator_guard_if.sv
`default_nettype none
// ============================================================================
// Module   : actuator_guard_if
// Brief    : Request/drive bundle between decision logic and the actuator guard.
// Revision : 1.0 - initial release
// ============================================================================
interface actuator_guard_if;
    logic       ena;
    logic [3:0] req;
    logic       override;
    logic       clr_timeout;
    logic [3:0] drive;
    logic [3:0] timeout;
    logic [2:0] active_cnt;

    modport master (
        output ena, req, override, clr_timeout,
        input  drive, timeout, active_cnt
    );

    modport slave (
        input  ena, req, override, clr_timeout,
        output drive, timeout, active_cnt
    );
endinterface
`default_nettype wire

// File: rtl/actuator_guard.sv
`default_nettype none
// ============================================================================
// Module   : actuator_guard
// Brief    : Per-channel min-on/min-off/max-on protection with load budget
//            and one-start-per-cycle staggering for four relay drives.
// Revision : 1.0 - initial release
// ============================================================================
module actuator_guard #(
    parameter int TICK_DIV   = 25000,
    parameter int CNT_W      = 8,
    parameter int MIN_ON     = 3,
    parameter int MIN_OFF    = 2,
    parameter int MAX_ON     = 200,
    parameter int MAX_ACTIVE = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    actuator_guard_if.slave  bus
);

    localparam int               c_pw         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0]  c_presc_last = c_pw'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_min_on     = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] c_min_off    = CNT_W'(MIN_OFF);
    localparam logic [CNT_W-1:0] c_max_on_m1  = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [2:0]       c_max_active = 3'(MAX_ACTIVE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;

    logic [c_pw-1:0] r_presc;
    logic            w_tick;
    logic [3:0]      r_drive;
    logic [3:0]      r_timeout;
    logic [2:0]      r_active_cnt;
    logic [3:0]      w_elig;
    logic [3:0]      w_grant;
    logic [3:0]      w_drive_nxt;
    logic [3:0]      w_to_set;
    logic [2:0]      w_cnt_nxt;

    assign w_tick  = bus.ena && (r_presc == c_presc_last);
    // Isolate the lowest set bit: only one channel may start per cycle.
    assign w_grant = w_elig & (~w_elig + 4'd1);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [1:0]       r_state, w_state_nxt;
            logic [CNT_W-1:0] r_min_cnt, w_min_nxt;
            logic [CNT_W-1:0] r_on_cnt, w_on_nxt;
            logic [CNT_W-1:0] r_off_cnt, w_off_nxt;
            logic             w_min_done;
            logic             w_off_done;

            assign w_elig[gi] = (r_state == S_IDLE) && bus.req[gi] && !r_timeout[gi] &&
                                !bus.override && bus.ena && (r_active_cnt < c_max_active);

            // Counting the expiring tick as done keeps durations within one tick period.
            assign w_min_done = (r_min_cnt == '0) || (w_tick && (r_min_cnt == c_one));
            assign w_off_done = (r_off_cnt == '0) || (w_tick && (r_off_cnt == c_one));

            always_comb begin
                w_state_nxt  = r_state;
                w_min_nxt    = r_min_cnt;
                w_on_nxt     = r_on_cnt;
                w_off_nxt    = r_off_cnt;
                w_to_set[gi] = 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_grant[gi]) begin
                            w_state_nxt = S_ON;
                            w_min_nxt   = c_min_on;
                            w_on_nxt    = '0;
                        end
                    end
                    S_ON: begin
                        if (bus.override) begin
                            w_state_nxt = S_COOL;
                            w_off_nxt   = c_min_off;
                        end else if (bus.ena) begin
                            if (w_tick) begin
                                if (r_min_cnt != '0) w_min_nxt = r_min_cnt - c_one;
                                w_on_nxt = r_on_cnt + c_one;
                            end
                            if (w_tick && (r_on_cnt == c_max_on_m1)) begin
                                w_state_nxt  = S_COOL;
                                w_off_nxt    = c_min_off;
                                w_to_set[gi] = 1'b1;
                            end else if (w_min_done && !bus.req[gi]) begin
                                w_state_nxt = S_COOL;
                                w_off_nxt   = c_min_off;
                            end
                        end
                    end
                    S_COOL: begin
                        if (bus.ena) begin
                            if (w_tick && (r_off_cnt != '0)) w_off_nxt = r_off_cnt - c_one;
                            if (w_off_done) w_state_nxt = S_IDLE;
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end

            assign w_drive_nxt[gi] = (w_state_nxt == S_ON);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state   <= S_IDLE;
                    r_min_cnt <= '0;
                    r_on_cnt  <= '0;
                    r_off_cnt <= '0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_min_cnt <= w_min_nxt;
                    r_on_cnt  <= w_on_nxt;
                    r_off_cnt <= w_off_nxt;
                end
            end
        end
    endgenerate

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            w_cnt_nxt = w_cnt_nxt + 3'(w_drive_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_drive      <= '0;
            r_timeout    <= '0;
            r_active_cnt <= '0;
        end else begin
            if (bus.ena) begin
                r_presc <= w_tick ? '0 : r_presc + c_pw'(1);
            end
            r_drive      <= w_drive_nxt;
            // A new fault on the same edge as a clear must survive.
            r_timeout    <= (r_timeout & ~{4{bus.clr_timeout}}) | w_to_set;
            r_active_cnt <= w_cnt_nxt;
        end
    end

    assign bus.drive      = r_drive;
    assign bus.timeout    = r_timeout;
    assign bus.active_cnt = r_active_cnt;

endmodule
`default_nettype wire
